meteor_reset_ctrl: RTL and testbench

//  Reset sequencer for the meteorolite SoC. Sits between the board reset pins (CB_nPOR,
//  CB_nRST), the debug reset (CS_nSRST) and the core/peripheral reset requests. Produces the

---
 rtl/meteor_reset_ctrl.sv | 219 +++++++++++++++++++++
 tb/tb_meteor_reset_ctrl.sv | 408 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/meteor_reset_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : meteor_reset_ctrl
// Purpose  : Reset sequencer for the meteorolite SoC. Synchronises and filters
//            the board/debug reset pins, orders the PORESETn/HRESETn release
//            for the Cortex-M3 subsystem and keeps a sticky reset-cause vector.
// Ports    : OSCCLK        - sole clock
//            CB_nPOR       - async active-low power-on reset (clears all flops)
//            CB_nRST       - push-button reset, async, active-low, bouncy
//            CS_nSRST      - debugger system reset, async, active-low
//            PLL_LOCKED    - clock-generator lock, async
//            SYSRESETREQ   - core reset request (OSCCLK domain, level)
//            WDOGRES       - watchdog reset (OSCCLK domain, level)
//            LOCKUP        - core lockup (only used with LOCKUP_RESET_EN)
//            PORESETn      - power-on reset to core/debug, active-low
//            HRESETn       - system reset to core/bus/peripherals, active-low
//            FLAG_NPOR     - copy of PORESETn (same flop)
//            FLAG_RESET_N  - copy of HRESETn (same flop)
//            RST_CAUSE     - sticky cause [0]POR [1]pin [2]debug [3]sysreq
//                            [4]wdog [5]lockup
// Config   : define LOCKUP_RESET_EN to make LOCKUP a system reset source.
// Revision : 1.0 - initial release
// ============================================================================
module meteor_reset_ctrl #(
  parameter int SYNC_STAGES  = 2,
  parameter int DEBOUNCE_CYC = 16,
  parameter int POR_HOLD_CYC = 64,
  parameter int SYS_HOLD_CYC = 16,
  parameter int CNT_W        = 8
) (
  input  logic       OSCCLK,
  input  logic       CB_nPOR,
  input  logic       CB_nRST,
  input  logic       CS_nSRST,
  input  logic       PLL_LOCKED,
  input  logic       SYSRESETREQ,
  input  logic       WDOGRES,
  input  logic       LOCKUP,
  output logic       PORESETn,
  output logic       HRESETn,
  output logic       FLAG_NPOR,
  output logic       FLAG_RESET_N,
  output logic [5:0] RST_CAUSE
);

  typedef enum logic [1:0] {
    S_POR  = 2'd0,
    S_SYSH = 2'd1,
    S_RUN  = 2'd2,
    S_SREQ = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] c_one      = CNT_W'(1);
  localparam logic [CNT_W-1:0] c_deb_last = CNT_W'(DEBOUNCE_CYC - 1);
  localparam logic [CNT_W-1:0] c_por_last = CNT_W'(POR_HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] c_sys_last = CNT_W'(SYS_HOLD_CYC - 1);
  localparam logic [5:0]       c_cause_por = 6'b000001;

  // --------------------------------------------------------------------------
  // Input synchronisers. Resets sit at the "released" level so a cold start
  // never looks like a pin reset; PLL lock starts as unlocked.
  // --------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] r_nrst_sync;
  logic [SYNC_STAGES-1:0] r_srst_sync;
  logic [SYNC_STAGES-1:0] r_pll_sync;

  always_ff @(posedge OSCCLK or negedge CB_nPOR) begin
    if (!CB_nPOR) begin
      r_nrst_sync <= '1;
      r_srst_sync <= '1;
      r_pll_sync  <= '0;
    end else begin
      r_nrst_sync <= {r_nrst_sync[SYNC_STAGES-2:0], CB_nRST};
      r_srst_sync <= {r_srst_sync[SYNC_STAGES-2:0], CS_nSRST};
      r_pll_sync  <= {r_pll_sync[SYNC_STAGES-2:0], PLL_LOCKED};
    end
  end

  logic w_nrst_s;
  logic w_srst_s;
  logic w_pll_s;
  assign w_nrst_s = r_nrst_sync[SYNC_STAGES-1];
  assign w_srst_s = r_srst_sync[SYNC_STAGES-1];
  assign w_pll_s  = r_pll_sync[SYNC_STAGES-1];

  // --------------------------------------------------------------------------
  // Push-button debounce: the filtered level only follows the pin after
  // DEBOUNCE_CYC consecutive samples that disagree with it.
  // --------------------------------------------------------------------------
  logic             r_pin_filt;
  logic [CNT_W-1:0] r_deb_cnt;

  always_ff @(posedge OSCCLK or negedge CB_nPOR) begin
    if (!CB_nPOR) begin
      r_pin_filt <= 1'b1;
      r_deb_cnt  <= '0;
    end else if (w_nrst_s != r_pin_filt) begin
      if (r_deb_cnt == c_deb_last) begin
        r_pin_filt <= w_nrst_s;
        r_deb_cnt  <= '0;
      end else begin
        r_deb_cnt  <= r_deb_cnt + c_one;
      end
    end else begin
      r_deb_cnt <= '0;
    end
  end

  // --------------------------------------------------------------------------
  // System reset sources, laid out in RST_CAUSE bit order so the vector can
  // be latched directly on request entry.
  // --------------------------------------------------------------------------
  logic w_lockup_src;
`ifdef LOCKUP_RESET_EN
  assign w_lockup_src = LOCKUP;
`else
  logic w_unused_lockup;
  assign w_unused_lockup = LOCKUP;
  assign w_lockup_src    = 1'b0;
`endif

  logic [5:0] w_src;
  logic       w_sys_req;
  assign w_src     = {w_lockup_src, WDOGRES, SYSRESETREQ, ~w_srst_s, ~r_pin_filt, 1'b0};
  assign w_sys_req = |w_src;

  // --------------------------------------------------------------------------
  // Sequencer
  // --------------------------------------------------------------------------
  state_t           r_state;
  state_t           w_state_nx;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nx;
  logic [5:0]       r_rst_cause;
  logic [5:0]       w_cause_nx;
  logic             r_poreset_n;
  logic             r_hreset_n;

  always_ff @(posedge OSCCLK or negedge CB_nPOR) begin
    if (!CB_nPOR) begin
      r_state     <= S_POR;
      r_cnt       <= '0;
      r_rst_cause <= c_cause_por;
      r_poreset_n <= 1'b0;
      r_hreset_n  <= 1'b0;
    end else begin
      r_state     <= w_state_nx;
      r_cnt       <= w_cnt_nx;
      r_rst_cause <= w_cause_nx;
      // Outputs decoded from the next state so each pin is a single flop and
      // HRESETn drops on the same edge the request is accepted.
      r_poreset_n <= (w_state_nx != S_POR);
      r_hreset_n  <= (w_state_nx == S_RUN);
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_cause_nx = r_rst_cause;
    // Loss of lock outside S_POR is a full power-on reset and overrides any
    // pending system reset handling.
    if ((r_state != S_POR) && !w_pll_s) begin
      w_state_nx = S_POR;
      w_cnt_nx   = '0;
      w_cause_nx = c_cause_por;
    end else begin
      case (r_state)
        S_POR: begin
          if (!w_pll_s) begin
            w_cnt_nx = '0;
          end else if (r_cnt == c_por_last) begin
            w_state_nx = S_SYSH;
            w_cnt_nx   = '0;
          end else begin
            w_cnt_nx = r_cnt + c_one;
          end
        end
        S_SYSH: begin
          if (w_sys_req) begin
            w_state_nx = S_SREQ;
            w_cnt_nx   = '0;
            w_cause_nx = w_src;
          end else if (r_cnt == c_sys_last) begin
            w_state_nx = S_RUN;
            w_cnt_nx   = '0;
          end else begin
            w_cnt_nx = r_cnt + c_one;
          end
        end
        S_RUN: begin
          if (w_sys_req) begin
            w_state_nx = S_SREQ;
            w_cnt_nx   = '0;
            w_cause_nx = w_src;
          end
        end
        S_SREQ: begin
          if (!w_sys_req) begin
            w_state_nx = S_SYSH;
            w_cnt_nx   = '0;
          end
        end
        default: begin
          w_state_nx = S_POR;
          w_cnt_nx   = '0;
        end
      endcase
    end
  end

  assign PORESETn     = r_poreset_n;
  assign HRESETn      = r_hreset_n;
  assign FLAG_NPOR    = r_poreset_n;
  assign FLAG_RESET_N = r_hreset_n;
  assign RST_CAUSE    = r_rst_cause;

endmodule
`default_nettype wire

// File: tb/tb_meteor_reset_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_meteor_reset_ctrl
// Purpose  : Self-checking bench for meteor_reset_ctrl. A behavioural model
//            predicts every change of the output pins and queues it with the
//            cycle it should appear on; a monitor compares DUT changes against
//            that queue. Directed scenarios are followed by random traffic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_meteor_reset_ctrl;

  localparam int SYNC_STAGES  = 2;
  localparam int DEBOUNCE_CYC = 16;
  localparam int POR_HOLD_CYC = 64;
  localparam int SYS_HOLD_CYC = 16;
  localparam int CNT_W        = 8;

  logic       OSCCLK      = 1'b0;
  logic       CB_nPOR     = 1'b0;
  logic       CB_nRST     = 1'b1;
  logic       CS_nSRST    = 1'b1;
  logic       PLL_LOCKED  = 1'b1;
  logic       SYSRESETREQ = 1'b0;
  logic       WDOGRES     = 1'b0;
  logic       LOCKUP      = 1'b0;
  logic       PORESETn;
  logic       HRESETn;
  logic       FLAG_NPOR;
  logic       FLAG_RESET_N;
  logic [5:0] RST_CAUSE;

  meteor_reset_ctrl #(
    .SYNC_STAGES (SYNC_STAGES),
    .DEBOUNCE_CYC(DEBOUNCE_CYC),
    .POR_HOLD_CYC(POR_HOLD_CYC),
    .SYS_HOLD_CYC(SYS_HOLD_CYC),
    .CNT_W       (CNT_W)
  ) dut (
    .OSCCLK      (OSCCLK),
    .CB_nPOR     (CB_nPOR),
    .CB_nRST     (CB_nRST),
    .CS_nSRST    (CS_nSRST),
    .PLL_LOCKED  (PLL_LOCKED),
    .SYSRESETREQ (SYSRESETREQ),
    .WDOGRES     (WDOGRES),
    .LOCKUP      (LOCKUP),
    .PORESETn    (PORESETn),
    .HRESETn     (HRESETn),
    .FLAG_NPOR   (FLAG_NPOR),
    .FLAG_RESET_N(FLAG_RESET_N),
    .RST_CAUSE   (RST_CAUSE)
  );

  always #5 OSCCLK = ~OSCCLK;

  int checks = 0;
  int errors = 0;

  // --------------------------------------------------------------------------
  // Reference model: input histories as queues, debounce as a run length of
  // disagreeing samples, reset phases as flags with elapsed-cycle timers.
  // --------------------------------------------------------------------------
  typedef struct {
    int         cyc;
    logic       por;
    logic       hrs;
    logic [5:0] cause;
  } ev_t;

  ev_t  exp_q[$];
  int   cyc = 0;

  logic m_nrst_h[$];
  logic m_srst_h[$];
  logic m_pll_h[$];
  logic m_filt = 1'b1;
  int   m_run = 0;
  logic m_in_por = 1'b1;
  logic m_holding = 1'b0;
  logic m_waiting = 1'b0;
  logic m_running = 1'b0;
  int   m_lock = 0;
  int   m_hold = 0;
  logic [5:0] m_cause = 6'b000001;
  logic m_last_por = 1'b0;
  logic m_last_hrs = 1'b0;
  logic [5:0] m_last_cause = 6'b000001;

  task automatic model_emit();
    ev_t e;
    logic por_o;
    logic hrs_o;
    por_o = !m_in_por;
    hrs_o = m_running;
    if (por_o != m_last_por || hrs_o != m_last_hrs || m_cause != m_last_cause) begin
      e.cyc   = cyc;
      e.por   = por_o;
      e.hrs   = hrs_o;
      e.cause = m_cause;
      exp_q.push_back(e);
      m_last_por   = por_o;
      m_last_hrs   = hrs_o;
      m_last_cause = m_cause;
    end
  endtask

  task automatic model_reset();
    m_nrst_h = {};
    m_srst_h = {};
    m_pll_h  = {};
    for (int i = 0; i < SYNC_STAGES; i++) begin
      m_nrst_h.push_back(1'b1);
      m_srst_h.push_back(1'b1);
      m_pll_h.push_back(1'b0);
    end
    m_filt    = 1'b1;
    m_run     = 0;
    m_in_por  = 1'b1;
    m_holding = 1'b0;
    m_waiting = 1'b0;
    m_running = 1'b0;
    m_lock    = 0;
    m_hold    = 0;
    m_cause   = 6'b000001;
    model_emit();
  endtask

  task automatic model_step();
    logic       pin_s;
    logic       srst_s;
    logic       pll_s;
    logic [5:0] src;
    logic       req;
    pin_s  = m_nrst_h[0];
    srst_s = m_srst_h[0];
    pll_s  = m_pll_h[0];
    src    = 6'b000000;
    src[1] = !m_filt;
    src[2] = !srst_s;
    src[3] = SYSRESETREQ;
    src[4] = WDOGRES;
`ifdef LOCKUP_RESET_EN
    src[5] = LOCKUP;
`endif
    req = (src != 6'b000000);

    if (m_in_por) begin
      if (pll_s) begin
        m_lock++;
        if (m_lock == POR_HOLD_CYC) begin
          m_in_por  = 1'b0;
          m_holding = 1'b1;
          m_hold    = 0;
        end
      end else begin
        m_lock = 0;
      end
    end else if (!pll_s) begin
      m_in_por  = 1'b1;
      m_holding = 1'b0;
      m_waiting = 1'b0;
      m_running = 1'b0;
      m_lock    = 0;
      m_cause   = 6'b000001;
    end else if (m_waiting) begin
      if (!req) begin
        m_waiting = 1'b0;
        m_holding = 1'b1;
        m_hold    = 0;
      end
    end else if (req) begin
      m_holding = 1'b0;
      m_running = 1'b0;
      m_waiting = 1'b1;
      m_cause   = src;
    end else if (m_holding) begin
      m_hold++;
      if (m_hold == SYS_HOLD_CYC) begin
        m_holding = 1'b0;
        m_running = 1'b1;
      end
    end

    if (pin_s != m_filt) begin
      m_run++;
      if (m_run == DEBOUNCE_CYC) begin
        m_filt = pin_s;
        m_run  = 0;
      end
    end else begin
      m_run = 0;
    end

    m_nrst_h.push_back(CB_nRST);
    m_srst_h.push_back(CS_nSRST);
    m_pll_h.push_back(PLL_LOCKED);
    void'(m_nrst_h.pop_front());
    void'(m_srst_h.pop_front());
    void'(m_pll_h.pop_front());
    model_emit();
  endtask

  always @(posedge OSCCLK or negedge CB_nPOR) begin
    if (!CB_nPOR) begin
      model_reset();
    end else begin
      cyc++;
      model_step();
    end
  end

  // --------------------------------------------------------------------------
  // Monitor: every change on the output pins must match the next queued
  // prediction, including the cycle it was predicted for.
  // --------------------------------------------------------------------------
  logic       mon_en = 1'b0;
  logic [9:0] last_dut;
  logic [9:0] cur_dut;
  ev_t        mon_e;

  always @(posedge OSCCLK or negedge CB_nPOR) begin
    if (mon_en) begin
      #1;
      cur_dut = {PORESETn, HRESETn, FLAG_NPOR, FLAG_RESET_N, RST_CAUSE};
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        checks++;
        errors++;
        $display("FAIL missed_event: output unchanged at cyc=%0d (por,hrs,flags,cause=%b), required por=%b hrs=%b cause=%b at cyc=%0d",
                 cyc, cur_dut, exp_q[0].por, exp_q[0].hrs, exp_q[0].cause, exp_q[0].cyc);
        void'(exp_q.pop_front());
      end
      if (cur_dut !== last_dut) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_change: cyc=%0d got por,hrs,flags,cause=%b, no change required", cyc, cur_dut);
        end else begin
          mon_e = exp_q.pop_front();
          if (mon_e.cyc != cyc ||
              cur_dut !== {mon_e.por, mon_e.hrs, mon_e.por, mon_e.hrs, mon_e.cause}) begin
            errors++;
            $display("FAIL output_event: got cyc=%0d por,hrs,flags,cause=%b, required cyc=%0d por=%b hrs=%b cause=%b",
                     cyc, cur_dut, mon_e.cyc, mon_e.por, mon_e.hrs, mon_e.cause);
          end
        end
        last_dut = cur_dut;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Stimulus and directed spot checks against spec-derived constants
  // --------------------------------------------------------------------------
  task automatic check(input string name, input logic [7:0] got, input logic [7:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %b required %b", name, got, want);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge OSCCLK);
  endtask

  initial begin
    int kind;
    int len;

    idle(3);
    check("reset_poresetn", {7'd0, PORESETn}, 8'd0);
    check("reset_hresetn", {7'd0, HRESETn}, 8'd0);
    check("reset_flags", {6'd0, FLAG_NPOR, FLAG_RESET_N}, 8'd0);
    check("reset_cause", {2'd0, RST_CAUSE}, 8'b00000001);
    last_dut = {PORESETn, HRESETn, FLAG_NPOR, FLAG_RESET_N, RST_CAUSE};
    mon_en   = 1'b1;

    // Cold start with PLL already locked
    CB_nPOR = 1'b1;
    idle(SYNC_STAGES + POR_HOLD_CYC - 1);
    check("por_hold_last", {7'd0, PORESETn}, 8'd0);
    idle(1);
    check("por_release", {6'd0, PORESETn, HRESETn}, 8'b00000010);
    idle(SYS_HOLD_CYC - 1);
    check("sys_hold_last", {7'd0, HRESETn}, 8'd0);
    idle(1);
    check("sys_release", {7'd0, HRESETn}, 8'd1);
    check("cause_cold", {2'd0, RST_CAUSE}, 8'b00000001);
    idle(5);

    // Three-cycle core reset request
    SYSRESETREQ = 1'b1;
    idle(1);
    check("sysreq_hreset_low", {6'd0, PORESETn, HRESETn}, 8'b00000010);
    idle(2);
    SYSRESETREQ = 1'b0;
    idle(SYS_HOLD_CYC);
    check("sysreq_hold_last", {7'd0, HRESETn}, 8'd0);
    idle(1);
    check("sysreq_release", {7'd0, HRESETn}, 8'd1);
    check("cause_sysreq", {2'd0, RST_CAUSE}, 8'b00001000);
    idle(5);

    // Bouncy pin: short glitches are ignored, a long press resets
    for (int g = 0; g < 3; g++) begin
      CB_nRST = 1'b0;
      idle(5);
      CB_nRST = 1'b1;
      idle(10);
    end
    check("glitch_ignored", {7'd0, HRESETn}, 8'd1);
    CB_nRST = 1'b0;
    idle(SYNC_STAGES + DEBOUNCE_CYC);
    check("pin_before_reset", {7'd0, HRESETn}, 8'd1);
    idle(2);
    check("pin_reset", {7'd0, HRESETn}, 8'd0);
    idle(40 - SYNC_STAGES - DEBOUNCE_CYC - 2);
    CB_nRST = 1'b1;
    idle(60);
    check("cause_pin", {2'd0, RST_CAUSE}, 8'b00000010);
    check("pin_recovered", {7'd0, HRESETn}, 8'd1);

    // Simultaneous sources, then lockup on its own
    WDOGRES     = 1'b1;
    SYSRESETREQ = 1'b1;
    idle(2);
    WDOGRES     = 1'b0;
    SYSRESETREQ = 1'b0;
    idle(30);
    check("cause_multi", {2'd0, RST_CAUSE}, 8'b00011000);
    LOCKUP = 1'b1;
    idle(3);
`ifdef LOCKUP_RESET_EN
    check("lockup_reset", {7'd0, HRESETn}, 8'd0);
    LOCKUP = 1'b0;
    idle(30);
    check("cause_lockup", {2'd0, RST_CAUSE}, 8'b00100000);
`else
    check("lockup_ignored", {7'd0, HRESETn}, 8'd1);
    LOCKUP = 1'b0;
    idle(30);
    check("cause_lockup_ignored", {2'd0, RST_CAUSE}, 8'b00011000);
`endif

    // Debugger reset
    CS_nSRST = 1'b0;
    idle(6);
    CS_nSRST = 1'b1;
    idle(30);
    check("cause_debug", {2'd0, RST_CAUSE}, 8'b00000100);

    // Loss of PLL lock while running, then relock
    PLL_LOCKED = 1'b0;
    idle(SYNC_STAGES + 1);
    check("pll_loss_outputs", {6'd0, PORESETn, HRESETn}, 8'd0);
    check("cause_pll", {2'd0, RST_CAUSE}, 8'b00000001);
    idle(4);
    PLL_LOCKED = 1'b1;
    idle(SYNC_STAGES + POR_HOLD_CYC + SYS_HOLD_CYC + 4);
    check("relock_outputs", {6'd0, PORESETn, HRESETn}, 8'b00000011);

    // Power-on reset while a system reset request is pending
    SYSRESETREQ = 1'b1;
    idle(4);
    #2;
    CB_nPOR = 1'b0;
    #1;
    check("async_por_outputs", {4'd0, PORESETn, HRESETn, FLAG_NPOR, FLAG_RESET_N}, 8'd0);
    check("async_por_cause", {2'd0, RST_CAUSE}, 8'b00000001);
    idle(3);
    SYSRESETREQ = 1'b0;
    CB_nPOR     = 1'b1;
    idle(SYNC_STAGES + POR_HOLD_CYC + SYS_HOLD_CYC + 4);
    check("post_por_running", {6'd0, PORESETn, HRESETn}, 8'b00000011);

    // Random traffic checked only through the scoreboard
    for (int i = 0; i < 40; i++) begin
      kind = int'($urandom_range(0, 5));
      len  = (kind == 3) ? int'($urandom_range(1, 40)) : int'($urandom_range(1, 8));
      case (kind)
        0: SYSRESETREQ = 1'b1;
        1: WDOGRES     = 1'b1;
        2: CS_nSRST    = 1'b0;
        3: CB_nRST     = 1'b0;
        4: PLL_LOCKED  = 1'b0;
        default: LOCKUP = 1'b1;
      endcase
      if ($urandom_range(0, 3) == 0) WDOGRES = 1'b1;
      idle(len);
      SYSRESETREQ = 1'b0;
      WDOGRES     = 1'b0;
      CS_nSRST    = 1'b1;
      CB_nRST     = 1'b1;
      PLL_LOCKED  = 1'b1;
      LOCKUP      = 1'b0;
      idle(int'($urandom_range(0, 90)));
    end

    idle(150);
    check("scoreboard_drained", 8'(exp_q.size()), 8'd0);
    check("final_running", {6'd0, PORESETn, HRESETn}, 8'b00000011);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
